divider_imp_2: RTL and testbench
================================

Name: divider_imp_2

Overview:
- Sequential restoring shift-subtract divider, the inverse of the team's shift-add multiplier.
- Splits a 2*L_word dividend by an L_word divisor into an L_word quotient and an L_word remainder, one quotient bit per clock.
- Uses the same Start/Ready/Done handshake as the multiplier, so the two can share a host sequencer.
- Fast paths cover divide-by-zero, quotient overflow and zero dividend.

Parameters:
- L_word, default `word_size (4): operand word width; dividend is 2*L_word bits.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- dividend  input  2*L_word  numerator, sampled when Start accepted.
- divisor  input  L_word  denominator, sampled when Start accepted.
- Start  input  1  request; accepted only in a cycle where Ready=1.
- quotient  output  L_word  result, registered.
- remainder  output  L_word  result, registered.
- Ready  output  1  idle, can accept Start.
- Done  output  1  one-cycle pulse, results valid.
- Div_zero  output  1  divisor was 0, valid with Done.
- Overflow  output  1  quotient would exceed L_word bits, valid with Done.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; quotient, remainder, Ready, Done, Div_zero and Overflow all 0; internal registers 0. Ready rises at the first rising edge after reset releases. Reset mid-operation aborts, discards partial results and returns to IDLE.
- States: IDLE, DIVIDE, DONE. All outputs are registered. Ready=1 only in IDLE; Done=1 only in DONE.
- IDLE, Start=0: hold state; previous results and flags hold.
- IDLE, Start=1 at edge E0 (priority order):
  - divisor==0 -> DONE; quotient=0, remainder=0, Div_zero=1.
  - else dividend[2L-1:L] >= divisor -> DONE; quotient=0, remainder=0, Overflow=1.
  - else dividend==0 -> DONE; quotient=0, remainder=0, both flags 0.
  - else -> DIVIDE. Load partial remainder R (L_word+1 bits) = {0, dividend[2L-1:L]}, low shifter = dividend[L-1:0], iteration counter = L_word. Clear flags.
- DIVIDE, each edge:
  - T = {R[L-1:0], low MSB}; shift low left by 1.
  - If T >= {0, divisor}: R = T - divisor and shift quotient bit 1 into the LSB.
  - Else: R = T and shift quotient bit 0 into the LSB.
  - Decrement counter; when it reaches 0 -> DONE, and remainder = R[L-1:0].
  - Start is ignored throughout.
- DONE: Done=1 for exactly one cycle, then -> IDLE. Results and flags hold until the next accepted Start.
- Latency, normal path: Done is high in the cycle after edge E_L_word, and Ready returns after E_(L_word+1). Early paths: Done is high in the cycle after E0.
- Start held high continuously: a new operation is accepted on every IDLE cycle, giving back-to-back operations with one IDLE cycle between them.
- Invariant, non-flagged results: dividend == quotient*divisor + remainder, with remainder < divisor.

Decomposition:
- Shared include/package:
  - `word_size define.
  - State encoding localparams (IDLE, DIVIDE, DONE).
  - Counter width clog2(L_word+1).
- Sub-module divider_datapath_imp_2 holds the R/low/quotient shift-subtract registers, driven by load, step and clear strobes.
- divider_imp_2 keeps the FSM, counter, fast-path decode and flags.

Test Plan (L_word=4):
- dividend=0x64 (100), divisor=7, Start pulse -> quotient=14, remainder=2, Done after 4 iteration edges, flags 0.
- dividend=0xE1 (225), divisor=15 -> quotient=15, remainder=0 (maximum quotient, no overflow).
- divisor=0, dividend=0x35 -> Done the cycle after Start, Div_zero=1, quotient=0, remainder=0.
- dividend=0x70, divisor=7 -> Overflow=1, quotient=0, Done the cycle after Start. dividend=0, divisor=5 -> quotient=0, remainder=0, flags 0, early Done.
- 0x64/7 with Start re-pulsed during DIVIDE, operands changed to 0x10/3 -> Start ignored, result still 14 r 2. Then Start held high -> 0x10/3 = 5 r 1 accepted in the next IDLE cycle.
- Assert reset=0 after the second DIVIDE edge -> all outputs 0 immediately. Release -> Ready=1 after one edge. Rerun 0x64/7 -> 14 r 2.

Source files
------------

// File: rtl/divider_imp_2_pkg.sv
// rtl/divider_imp_2_pkg.sv - shared word size, FSM states and counter sizing for the divider
`ifndef WORD_SIZE
`define WORD_SIZE 4
`endif

package divider_imp_2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Iteration counter must hold the value L_word itself.
    function automatic int cnt_width(input int l_word);
        return $clog2(l_word + 1);
    endfunction

endpackage

// File: rtl/divider_datapath_imp_2.sv
// rtl/divider_datapath_imp_2.sv - restoring shift-subtract registers and result registers
module divider_datapath_imp_2
    import divider_imp_2_pkg::*;
#(
    parameter int L_word = `WORD_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic                  last,
    input  logic                  clear,
    input  logic [2*L_word-1:0]   dividend,
    input  logic [L_word-1:0]     divisor,
    output logic [L_word-1:0]     quotient,
    output logic [L_word-1:0]     remainder
);

    logic [L_word:0]   r_q, r_d, t;
    logic [L_word-1:0] low_q, quo_q, dvs_q, quo_d;
    logic              unused_rtop;

    always_comb begin
        t = {r_q[L_word-1:0], low_q[L_word-1]};
        if (t >= {1'b0, dvs_q}) begin
            r_d   = t - {1'b0, dvs_q};
            quo_d = {quo_q[L_word-2:0], 1'b1};
        end else begin
            r_d   = t;
            quo_d = {quo_q[L_word-2:0], 1'b0};
        end
    end

    // R never exceeds the divisor after a step, so its top bit is only headroom for the compare.
    assign unused_rtop = r_q[L_word] ^ r_d[L_word];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q       <= '0;
            low_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (clear) begin
            r_q       <= '0;
            low_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (load) begin
            r_q   <= {1'b0, dividend[2*L_word-1:L_word]};
            low_q <= dividend[L_word-1:0];
            quo_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            r_q   <= r_d;
            low_q <= {low_q[L_word-2:0], 1'b0};
            quo_q <= quo_d;
            if (last) begin
                quotient  <= quo_d;
                remainder <= r_d[L_word-1:0];
            end
        end
    end

endmodule

// File: rtl/divider_imp_2.sv
// rtl/divider_imp_2.sv - sequential restoring divider: FSM, iteration counter, fast paths and flags
module divider_imp_2
    import divider_imp_2_pkg::*;
#(
    parameter int L_word = `WORD_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2*L_word-1:0]   dividend,
    input  logic [L_word-1:0]     divisor,
    input  logic                  Start,
    output logic [L_word-1:0]     quotient,
    output logic [L_word-1:0]     remainder,
    output logic                  Ready,
    output logic                  Done,
    output logic                  Div_zero,
    output logic                  Overflow
);

    localparam int CW = cnt_width(L_word);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dz_d, ov_d;
    logic          load, step, last, clear;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dz_d    = Div_zero;
        ov_d    = Overflow;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Ready gates acceptance so the cycle right after reset release ignores Start.
                if (Ready && Start) begin
                    dz_d = 1'b0;
                    ov_d = 1'b0;
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        clear   = 1'b1;
                        state_d = ST_DONE;
                    end else if (dividend[2*L_word-1:L_word] >= divisor) begin
                        ov_d    = 1'b1;
                        clear   = 1'b1;
                        state_d = ST_DONE;
                    end else if (dividend == '0) begin
                        clear   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        load    = 1'b1;
                        cnt_d   = CW'(L_word);
                        state_d = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: begin
                step  = 1'b1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            Ready    <= 1'b0;
            Done     <= 1'b0;
            Div_zero <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            Ready    <= (state_d == ST_IDLE);
            Done     <= (state_d == ST_DONE);
            Div_zero <= dz_d;
            Overflow <= ov_d;
        end
    end

    divider_datapath_imp_2 #(.L_word(L_word)) u_datapath (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .last      (last),
        .clear     (clear),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder)
    );

endmodule

// File: tb/tb_divider_imp_2.sv
// tb/tb_divider_imp_2.sv - directed self-checking bench for divider_imp_2 with L_word=4
module tb_divider_imp_2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       Start = 1'b0;
    logic [3:0] quotient, remainder;
    logic       Ready, Done, Div_zero, Overflow;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    divider_imp_2 #(.L_word(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .dividend  (dividend),
        .divisor   (divisor),
        .Start     (Start),
        .quotient  (quotient),
        .remainder (remainder),
        .Ready     (Ready),
        .Done      (Done),
        .Div_zero  (Div_zero),
        .Overflow  (Overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Edges waited from now until Done is seen; a timeout is a failed check.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!Done && n < 30) begin
            tick();
            n++;
        end
        if (!Done) check({tag, "_timeout"}, 32'(Done), 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!Ready && n < 30) begin
            tick();
            n++;
        end
        if (!Ready) check({tag, "_ready_timeout"}, 32'(Ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] dvd, input logic [3:0] dvs,
                          input logic [3:0] eq, input logic [3:0] er,
                          input logic edz, input logic eov, input int elat);
        int n;
        wait_ready(tag);
        dividend = dvd;
        divisor  = dvs;
        Start    = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(tag, n);
        check({tag, "_lat"}, 32'(n), 32'(elat));
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_flags"}, {30'd0, Div_zero, Overflow}, {30'd0, edz, eov});
        tick();
        check({tag, "_done_pulse"}, 32'(Done), 32'd0);
    endtask

    initial begin
        int n;
        #2;
        check("reset_outs", {quotient, remainder, Ready, Done, Div_zero, Overflow},
              {4'd0, 4'd0, 4'b0000});
        #10 reset = 1'b1;
        #1;
        check("ready_before_edge", 32'(Ready), 32'd0);
        tick();
        check("ready_after_release", 32'(Ready), 32'd1);

        run_op("d100_7",   8'h64, 4'd7,  4'd14, 4'd2,  1'b0, 1'b0, 4);
        run_op("d225_15",  8'hE1, 4'd15, 4'd15, 4'd0,  1'b0, 1'b0, 4);
        run_op("divzero",  8'h35, 4'd0,  4'd0,  4'd0,  1'b1, 1'b0, 0);
        run_op("ovf_70_7", 8'h70, 4'd7,  4'd0,  4'd0,  1'b0, 1'b1, 0);
        run_op("zero_dvd", 8'h00, 4'd5,  4'd0,  4'd0,  1'b0, 1'b0, 0);
        run_op("d14_15",   8'h0E, 4'd15, 4'd0,  4'd14, 1'b0, 1'b0, 4);
        run_op("ovf_ff_1", 8'hFF, 4'd1,  4'd0,  4'd0,  1'b0, 1'b1, 0);

        // Start re-pulsed mid-divide with new operands, then held high.
        wait_ready("restart");
        dividend = 8'h64;
        divisor  = 4'd7;
        Start    = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        dividend = 8'h10;
        divisor  = 4'd3;
        Start    = 1'b1;
        wait_done("ignore_start", n);
        check("ignore_start_q", 32'(quotient), 32'd14);
        check("ignore_start_r", 32'(remainder), 32'd2);
        tick();
        check("held_idle_ready", 32'(Ready), 32'd1);
        tick();
        check("held_accepted", 32'(Ready), 32'd0);
        Start = 1'b0;
        wait_done("held", n);
        check("held_lat", 32'(n), 32'd4);
        check("held_q", 32'(quotient), 32'd5);
        check("held_r", 32'(remainder), 32'd1);

        // Reset mid-divide.
        wait_ready("midreset");
        dividend = 8'h64;
        divisor  = 4'd7;
        Start    = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midreset_outs", {quotient, remainder, Ready, Done, Div_zero, Overflow},
              {4'd0, 4'd0, 4'b0000});
        #2 reset = 1'b1;
        #1;
        check("midreset_ready_low", 32'(Ready), 32'd0);
        tick();
        check("midreset_ready", 32'(Ready), 32'd1);
        run_op("rerun", 8'h64, 4'd7, 4'd14, 4'd2, 1'b0, 1'b0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
